// File: rtl/pwm_capture_core.sv
// pwm_capture_core
//   Slot-mapped PWM input capture. Each channel measures the period and high
//   time of an external PWM signal in clk cycles. A per-channel timeout flags
//   inputs that have stopped toggling.
//
//   Optional feature macro: PWM_CAPTURE_IRQ_EN (adds IRQ_MASK at 0x03 and the
//   registered irq output). Without it, 0x03 reads 0 and irq does not exist.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   cs        slot chip select
//   read      slot read strobe (reads have no side effects)
//   write     slot write strobe
//   reg_addr  register address
//   wr_data   write data
//   rd_data   read data, combinational from reg_addr
//   pwm_in    asynchronous PWM inputs, one per channel
//   irq       interrupt request (PWM_CAPTURE_IRQ_EN only)
//
// Register map
//   0x00 CTRL     [IN_PORTS-1:0] channel enables
//   0x01 STATUS   [7:0] VALID (W1C), [15:8] STUCK (W1C), [23:16] live level
//   0x02 TIMEOUT  period_ctr value that declares a channel stuck, 0 = off
//   0x03 IRQ_MASK [7:0] VALID mask, [15:8] STUCK mask (optional)
//   0x1X          reg_addr[3:1] = channel, reg_addr[0] = 0 PERIOD / 1 HIGH
module pwm_capture_core #(
  parameter int IN_PORTS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                read,
  input  logic                write,
  input  logic [4:0]          reg_addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  input  logic [IN_PORTS-1:0] pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
  ,
  output logic                irq
`endif
);

  typedef enum logic [1:0] {
    ST_WAIT_EDGE,
    ST_MEASURE,
    ST_STUCK
  } state_e;

  localparam logic [31:0] CTR_MAX = 32'hFFFF_FFFF;

  // Reads have no side effects, so the strobe is intentionally unused.
  logic unused_read;
  assign unused_read = read;

  // Input synchronizer and edge detect
  logic [IN_PORTS-1:0] sync_q [SYNC_STAGES];
  logic [IN_PORTS-1:0] prev_q;
  logic [IN_PORTS-1:0] sync_lvl;
  logic [IN_PORTS-1:0] rise;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~prev_q;

  // Register file
  logic [IN_PORTS-1:0] ctrl_q;
  logic [31:0]         timeout_q;
  logic [IN_PORTS-1:0] valid_q, valid_d;
  logic [IN_PORTS-1:0] stuck_q, stuck_d;
  logic [IN_PORTS-1:0] set_valid, set_stuck;

  logic wr_en, wr_ctrl, wr_status, wr_timeout;
  assign wr_en      = cs && write;
  assign wr_ctrl    = wr_en && (reg_addr == 5'h00);
  assign wr_status  = wr_en && (reg_addr == 5'h01);
  assign wr_timeout = wr_en && (reg_addr == 5'h02);

  // Per-channel measurement state
  state_e      state_q      [IN_PORTS];
  state_e      state_d      [IN_PORTS];
  logic [31:0] period_ctr_q [IN_PORTS];
  logic [31:0] period_ctr_d [IN_PORTS];
  logic [31:0] high_ctr_q   [IN_PORTS];
  logic [31:0] high_ctr_d   [IN_PORTS];
  logic [31:0] period_q     [IN_PORTS];
  logic [31:0] period_d     [IN_PORTS];
  logic [31:0] high_q       [IN_PORTS];
  logic [31:0] high_d       [IN_PORTS];

  // NOTE: every output of this block is given a default before any branch,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    for (int c = 0; c < IN_PORTS; c++) begin
      state_d[c]      = state_q[c];
      period_ctr_d[c] = period_ctr_q[c];
      high_ctr_d[c]   = high_ctr_q[c];
      period_d[c]     = period_q[c];
      high_d[c]       = high_q[c];
      set_valid[c]    = 1'b0;
      set_stuck[c]    = 1'b0;

      if (!ctrl_q[c]) begin
        // Disabled: drop the measurement, keep captured results and flags.
        state_d[c]      = ST_WAIT_EDGE;
        period_ctr_d[c] = '0;
        high_ctr_d[c]   = '0;
      end else begin
        unique case (state_q[c])
          ST_MEASURE: begin
            if (rise[c]) begin
              // Capture has priority over a coincident timeout.
              period_d[c]     = period_ctr_q[c];
              high_d[c]       = high_ctr_q[c];
              set_valid[c]    = 1'b1;
              period_ctr_d[c] = 32'd1;
              high_ctr_d[c]   = 32'd1;
            end else if ((timeout_q != '0) && (period_ctr_q[c] == timeout_q)) begin
              set_stuck[c]    = 1'b1;
              state_d[c]      = ST_STUCK;
              period_ctr_d[c] = '0;
              high_ctr_d[c]   = '0;
            end else begin
              // Saturate rather than wrap when no timeout is armed.
              if (period_ctr_q[c] != CTR_MAX) period_ctr_d[c] = period_ctr_q[c] + 32'd1;
              if (sync_lvl[c] && (high_ctr_q[c] != CTR_MAX)) high_ctr_d[c] = high_ctr_q[c] + 32'd1;
            end
          end
          default: begin  // ST_WAIT_EDGE and ST_STUCK: idle until a rising edge
            period_ctr_d[c] = '0;
            high_ctr_d[c]   = '0;
            if (rise[c]) begin
              state_d[c]      = ST_MEASURE;
              period_ctr_d[c] = 32'd1;
              high_ctr_d[c]   = 32'd1;
            end
          end
        endcase
      end
    end
  end

  // Hardware set wins over a software clear of the same bit.
  always_comb begin
    valid_d = valid_q & ~(wr_status ? wr_data[IN_PORTS-1:0]   : '0) | set_valid;
    stuck_d = stuck_q & ~(wr_status ? wr_data[8 +: IN_PORTS] : '0) | set_stuck;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the captured-value arrays are reset along with everything else
  // because a reset must read back as all-zero registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q    <= '0;
      ctrl_q    <= '0;
      timeout_q <= '0;
      valid_q   <= '0;
      stuck_q   <= '0;
      for (int c = 0; c < IN_PORTS; c++) begin
        state_q[c]      <= ST_WAIT_EDGE;
        period_ctr_q[c] <= '0;
        high_ctr_q[c]   <= '0;
        period_q[c]     <= '0;
        high_q[c]       <= '0;
      end
    end else begin
      sync_q[0] <= pwm_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q  <= sync_lvl;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      if (wr_ctrl)    ctrl_q    <= wr_data[IN_PORTS-1:0];
      if (wr_timeout) timeout_q <= wr_data;
      for (int c = 0; c < IN_PORTS; c++) begin
        state_q[c]      <= state_d[c];
        period_ctr_q[c] <= period_ctr_d[c];
        high_ctr_q[c]   <= high_ctr_d[c];
        period_q[c]     <= period_d[c];
        high_q[c]       <= high_d[c];
      end
    end
  end

  // STATUS word, zero-padded to the fixed 8-bit fields.
  logic [31:0] status_word;
  always_comb begin
    status_word                  = '0;
    status_word[IN_PORTS-1:0]    = valid_q;
    status_word[8 +: IN_PORTS]   = stuck_q;
    status_word[16 +: IN_PORTS]  = sync_lvl;
  end

`ifdef PWM_CAPTURE_IRQ_EN
  logic [15:0] irq_mask_q;
  logic        irq_q;
  logic        wr_irq_mask;
  assign wr_irq_mask = wr_en && (reg_addr == 5'h03);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_irq_mask) irq_mask_q <= wr_data[15:0];
      irq_q <= |(status_word[15:0] & irq_mask_q);
    end
  end

  assign irq = irq_q;
`endif

  // Read mux
  always_comb begin
    rd_data = '0;
    if (reg_addr[4]) begin
      for (int c = 0; c < IN_PORTS; c++) begin
        if (reg_addr[3:1] == 3'(c)) rd_data = reg_addr[0] ? high_q[c] : period_q[c];
      end
    end else begin
      unique case (reg_addr[3:0])
        4'h0:    rd_data[IN_PORTS-1:0] = ctrl_q;
        4'h1:    rd_data = status_word;
        4'h2:    rd_data = timeout_q;
`ifdef PWM_CAPTURE_IRQ_EN
        4'h3:    rd_data = {16'h0, irq_mask_q};
`endif
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture_core.sv
// tb_pwm_capture_core
//   Directed bench for pwm_capture_core. Register reads push their expected
//   value into a scoreboard queue; a monitor pops and compares on the falling
//   edge of every cycle in which a read is presented.
module tb_pwm_capture_core;

  localparam int IN_PORTS    = 4;
  localparam int SYNC_STAGES = 2;

  localparam logic [4:0] A_CTRL    = 5'h00;
  localparam logic [4:0] A_STATUS  = 5'h01;
  localparam logic [4:0] A_TIMEOUT = 5'h02;
  localparam logic [4:0] A_IRQMASK = 5'h03;

  logic                clk;
  logic                reset;
  logic                cs;
  logic                read;
  logic                write;
  logic [4:0]          reg_addr;
  logic [31:0]         wr_data;
  logic [31:0]         rd_data;
  logic [IN_PORTS-1:0] pwm_in;
`ifdef PWM_CAPTURE_IRQ_EN
  logic                irq;
`endif

  pwm_capture_core #(
    .IN_PORTS    (IN_PORTS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .pwm_in   (pwm_in)
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
    bit          chk_irq;
    logic        exp_irq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: one comparison per presented read.
  always @(negedge clk) begin
    if (cs && read) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: addr=%h rd_data=%h with no expected entry", reg_addr, rd_data);
      end else begin
        mon_e = sb.pop_front();
        if ((rd_data & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h (mask %h)", mon_e.name, rd_data & mon_e.mask,
                   mon_e.exp & mon_e.mask, mon_e.mask);
        end
`ifdef PWM_CAPTURE_IRQ_EN
        if (mon_e.chk_irq) begin
          n_chk++;
          if (irq !== mon_e.exp_irq) begin
            n_fail++;
            $display("FAIL %s_irq: got %b required %b", mon_e.name, irq, mon_e.exp_irq);
          end
        end
`endif
      end
    end
  end

  // All bus tasks start and end at posedge+1.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
    step(1);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] e, input logic [31:0] m);
    exp_t x;
    x.name = nm; x.exp = e; x.mask = m; x.chk_irq = 1'b0; x.exp_irq = 1'b0;
    sb.push_back(x);
    cs = 1'b1; read = 1'b1; reg_addr = a;
    step(1);
    cs = 1'b0; read = 1'b0;
  endtask

`ifdef PWM_CAPTURE_IRQ_EN
  task automatic rd_irq(input string nm, input logic [4:0] a, input logic [31:0] e,
                        input logic [31:0] m, input logic ei);
    exp_t x;
    x.name = nm; x.exp = e; x.mask = m; x.chk_irq = 1'b1; x.exp_irq = ei;
    sb.push_back(x);
    cs = 1'b1; read = 1'b1; reg_addr = a;
    step(1);
    cs = 1'b0; read = 1'b0;
  endtask
`endif

  task automatic pulse(input int ch, input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in[ch] = 1'b1;
      step(hi);
      pwm_in[ch] = 1'b0;
      step(lo);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    reg_addr = '0; wr_data = '0; pwm_in = '0;
    step(3);

    // Reset state
    rd("rst_ctrl",    A_CTRL,    32'h0, 32'hFFFF_FFFF);
    rd("rst_status",  A_STATUS,  32'h0, 32'hFFFF_FFFF);
    rd("rst_timeout", A_TIMEOUT, 32'h0, 32'hFFFF_FFFF);
    rd("rst_period0", 5'h10,     32'h0, 32'hFFFF_FFFF);
    reset = 1'b0;
    step(2);

    // 1: ch0 30 high / 70 low, three periods
    wr(A_CTRL, 32'h1);
    rd("ctrl_rb", A_CTRL, 32'h1, 32'hFFFF_FFFF);
    fork
      pulse(0, 30, 70, 3);
      begin
        step(150);
        rd("t1_valid",   A_STATUS, 32'h1,  32'hFF);
        rd("t1_period0", 5'h10,    32'd100, 32'hFFFF_FFFF);
        rd("t1_high0",   5'h11,    32'd30,  32'hFFFF_FFFF);
      end
    join
    rd("t1_period0_again", 5'h10, 32'd100, 32'hFFFF_FFFF);
    rd("t1_high0_again",   5'h11, 32'd30,  32'hFFFF_FFFF);
    wr(A_STATUS, 32'h1);
    rd("t1_valid_clr", A_STATUS, 32'h0, 32'hFF);
    wr(A_CTRL, 32'h0);

    // 2: ch1 stuck high, timeout 500 counted from the counter start edge
    wr(A_TIMEOUT, 32'd500);
    wr(A_CTRL, 32'h2);
    pwm_in[1] = 1'b1;
    step(SYNC_STAGES + 500);
    rd("t2_stuck_early", A_STATUS, 32'h0,       32'h0000_0200);
    rd("t2_stuck_set",   A_STATUS, 32'h0002_0200, 32'h0002_0200);
    rd("t2_period1",     5'h12,    32'h0,       32'hFFFF_FFFF);
    rd("t2_high1",       5'h13,    32'h0,       32'hFFFF_FFFF);
    wr(A_STATUS, 32'h200);
    rd("t2_stuck_clr",   A_STATUS, 32'h0,       32'h0000_0200);
    pwm_in[1] = 1'b0;
    wr(A_CTRL, 32'h0);
    wr(A_TIMEOUT, 32'h0);

    // Unmapped addresses and channels beyond IN_PORTS
    rd("ch4_period", 5'h18, 32'h0, 32'hFFFF_FFFF);
    wr(5'h05, 32'hFFFF_FFFF);
    rd("unmapped_05", 5'h05, 32'h0, 32'hFFFF_FFFF);
`ifndef PWM_CAPTURE_IRQ_EN
    wr(A_IRQMASK, 32'hFFFF);
    rd("no_irqmask", A_IRQMASK, 32'h0, 32'hFFFF_FFFF);
`endif

    // 3: timeout disabled, single edge then low: nothing flagged
    wr(A_CTRL, 32'h4);
    pwm_in[2] = 1'b1;
    step(10);
    pwm_in[2] = 1'b0;
    step(600);
    rd("t3_no_flags", A_STATUS, 32'h0, 32'h0000_0404);
    rd("t3_period2",  5'h14,    32'h0, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h0);

    // 4: capture coincides with W1C of VALID[0]
    wr(A_CTRL, 32'h1);
    pwm_in[0] = 1'b1;
    step(10);
    pwm_in[0] = 1'b0;
    step(10);
    pwm_in[0] = 1'b1;
    step(SYNC_STAGES);
    wr(A_STATUS, 32'h1);
    rd("t4_set_wins", A_STATUS, 32'h1, 32'h1);
    wr(A_STATUS, 32'h1);
    rd("t4_cleared",  A_STATUS, 32'h0, 32'h1);
    rd("t4_period0",  5'h10,    32'd20, 32'hFFFF_FFFF);
    rd("t4_high0",    5'h11,    32'd10, 32'hFFFF_FFFF);

    // 5: disable mid-period, re-enable, fresh 50/25 measurement
    pwm_in[0] = 1'b0;
    step(5);
    wr(A_CTRL, 32'h0);
    step(3);
    wr(A_CTRL, 32'h1);
    pwm_in[0] = 1'b1;
    step(5);
    rd("t5_period_kept", 5'h10, 32'd20, 32'hFFFF_FFFF);
    step(19);
    pwm_in[0] = 1'b0;
    step(25);
    pwm_in[0] = 1'b1;
    step(10);
    rd("t5_period0", 5'h10,    32'd50, 32'hFFFF_FFFF);
    rd("t5_high0",   5'h11,    32'd25, 32'hFFFF_FFFF);
    rd("t5_valid",   A_STATUS, 32'h1,  32'h1);
    wr(A_STATUS, 32'h1);

`ifdef PWM_CAPTURE_IRQ_EN
    // 6: irq follows VALID[0] by one cycle and drops one cycle after W1C
    wr(A_IRQMASK, 32'h1);
    rd("t6_mask_rb", A_IRQMASK, 32'h1, 32'hFFFF_FFFF);
    pwm_in[0] = 1'b0;
    step(10);
    pwm_in[0] = 1'b1;
    step(SYNC_STAGES);
    rd_irq("t6_before",   A_STATUS, 32'h0, 32'h1, 1'b0);
    rd_irq("t6_valid",    A_STATUS, 32'h1, 32'h1, 1'b0);
    rd_irq("t6_irq",      A_STATUS, 32'h1, 32'h1, 1'b1);
    wr(A_STATUS, 32'h1);
    rd_irq("t6_clr",      A_STATUS, 32'h0, 32'h1, 1'b1);
    rd_irq("t6_irq_drop", A_STATUS, 32'h0, 32'h1, 1'b0);
`endif

    // Reset in the middle of a measurement
    wr(A_TIMEOUT, 32'd1000);
    pwm_in[0] = 1'b0;
    step(5);
    pwm_in[0] = 1'b1;
    step(7);
    reset = 1'b1;
    rd("mid_rst_ctrl",    A_CTRL,    32'h0, 32'hFFFF_FFFF);
    rd("mid_rst_timeout", A_TIMEOUT, 32'h0, 32'hFFFF_FFFF);
    rd("mid_rst_status",  A_STATUS,  32'h0, 32'hFFFF_FFFF);
    rd("mid_rst_period0", 5'h10,     32'h0, 32'hFFFF_FFFF);
    rd("mid_rst_high0",   5'h11,     32'h0, 32'hFFFF_FFFF);
`ifdef PWM_CAPTURE_IRQ_EN
    rd_irq("mid_rst_irqmask", A_IRQMASK, 32'h0, 32'hFFFF_FFFF, 1'b0);
`endif
    reset = 1'b0;
    step(2);

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
